fir_load_scheduler: RTL and testbench

FIR_LOAD_SCHEDULER -- requirements
Module: fir_load_scheduler

---
 rtl/fir_load_scheduler_if.sv | 41 ++++
 rtl/fir_load_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fir_load_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_load_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_load_scheduler_if
// Brief    : Loader/sample/FIR handshake bundle for fir_load_scheduler.
// Revision : 1.0
// ============================================================================
interface fir_load_scheduler_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                          coeff_req;
  logic [1:0]                    coeff_num;
  logic [DATA_W-1:0]             coeff_value;
  logic                          sample_valid;
  logic [DATA_W-1:0]             sample_value;
  logic                          modwait;
  logic                          clear_err;
  logic                          fir_load_coeff;
  logic                          fir_data_ready;
  logic [1:0]                    fir_coeff_num;
  logic [DATA_W-1:0]             fir_value;
  logic                          coeff_ack;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overrun;
  logic                          timeout_err;

  modport master (
    output coeff_req, coeff_num, coeff_value, sample_valid, sample_value,
           modwait, clear_err,
    input  fir_load_coeff, fir_data_ready, fir_coeff_num, fir_value,
           coeff_ack, fifo_count, overrun, timeout_err
  );

  modport slave (
    input  coeff_req, coeff_num, coeff_value, sample_valid, sample_value,
           modwait, clear_err,
    output fir_load_coeff, fir_data_ready, fir_coeff_num, fir_value,
           coeff_ack, fifo_count, overrun, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/fir_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_load_scheduler
// Brief    : Schedules coefficient loads and FIFO-buffered samples onto a FIR.
// Revision : 1.0
// ============================================================================
module fir_load_scheduler #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                reset,
  fir_load_scheduler_if.slave bus
);
  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ISSUE_C = 2'd1;
  localparam logic [1:0] c_ISSUE_S = 2'd2;
  localparam logic [1:0] c_WAIT    = 2'd3;

  localparam logic [c_TW-1:0] c_T_LAST   = c_TW'(TIMEOUT - 1);
  localparam logic [c_TW-1:0] c_T_ONE    = c_TW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [c_AW:0]   c_CNT_ONE  = (c_AW + 1)'(1);
  localparam logic [c_AW:0]   c_CNT_FULL = (c_AW + 1)'(FIFO_DEPTH);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [c_TW-1:0]   r_cnt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW:0]     r_count;
  logic [DATA_W-1:0] r_value;
  logic [1:0]        r_num;
  logic              r_lock;
  logic              r_overrun;
  logic              r_timeout;

  logic w_timeout;
  logic w_load_coeff;
  logic w_data_ready;
  logic w_ack;
  logic w_grant_c;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  // Samples are held back while a coefficient set is partially loaded.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (bus.coeff_req)                   w_next = c_ISSUE_C;
        else if (!r_lock && (r_count != '0)) w_next = c_ISSUE_S;
      end
      c_ISSUE_C, c_ISSUE_S: begin
        if (bus.modwait) begin
          w_next = c_WAIT;
        end else if (r_cnt == c_T_LAST) begin
          w_next    = c_IDLE;
          w_timeout = 1'b1;
        end
      end
      c_WAIT: begin
        if (!bus.modwait) w_next = c_IDLE;
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_load_coeff = (r_state == c_ISSUE_C);
    w_data_ready = (r_state == c_ISSUE_S);
    w_ack        = w_load_coeff && bus.modwait;
  end

  assign w_grant_c = (r_state == c_IDLE) && (w_next == c_ISSUE_C);
  assign w_pop     = (r_state == c_IDLE) && (w_next == c_ISSUE_S);
  assign w_push    = bus.sample_valid && ((r_count != c_CNT_FULL) || w_pop);
  assign w_drop    = bus.sample_valid && !w_push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_grant_c || w_pop) begin
      r_cnt <= '0;
    end else if ((r_state == c_ISSUE_C) || (r_state == c_ISSUE_S)) begin
      r_cnt <= r_cnt + c_T_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.sample_value;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value <= '0;
      r_num   <= '0;
    end else if (w_grant_c) begin
      r_value <= bus.coeff_value;
      r_num   <= bus.coeff_num;
    end else if (w_pop) begin
      r_value <= r_mem[r_rd_ptr];
    end
  end

  // An aborted coefficient load cannot complete the set, so it releases the lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_lock <= 1'b0;
    else if (w_ack)     r_lock <= (r_num != 2'd3);
    else if (w_timeout) r_lock <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_drop)             r_overrun <= 1'b1;
      else if (bus.clear_err) r_overrun <= 1'b0;
      if (w_timeout)          r_timeout <= 1'b1;
      else if (bus.clear_err) r_timeout <= 1'b0;
    end
  end

  assign bus.fir_load_coeff = w_load_coeff;
  assign bus.fir_data_ready = w_data_ready;
  assign bus.coeff_ack      = w_ack;
  assign bus.fir_value      = r_value;
  assign bus.fir_coeff_num  = r_num;
  assign bus.fifo_count     = r_count;
  assign bus.overrun        = r_overrun;
  assign bus.timeout_err    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_fir_load_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_load_scheduler
// Brief    : Queue-based reference model bench for fir_load_scheduler.
// Revision : 1.0
// ============================================================================
module tb_fir_load_scheduler;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int P_IDLE = 0, P_COEFF = 1, P_SAMPLE = 2, P_WAIT = 3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  int   fir_mode = 0;
  int   busy = 0;
  int   lag = 0;

  int          m_phase = P_IDLE;
  int          m_cnt = 0;
  logic [15:0] m_q [$];
  logic        m_lock = 1'b0;
  logic [15:0] m_val = '0;
  logic [1:0]  m_num = '0;
  logic        m_ovr = 1'b0;
  logic        m_tmo = 1'b0;

  logic [15:0] got_coeffs [$];
  logic [1:0]  got_nums [$];
  logic [15:0] got_samples [$];
  logic        prev_load = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] exp_s [6];

  fir_load_scheduler_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  fir_load_scheduler #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model: one IDLE decision, issue/wait bookkeeping, then the sample queue.
  always @(posedge clk or posedge reset) begin : model
    logic dropped;
    if (reset) begin
      m_phase = P_IDLE; m_cnt = 0; m_q.delete(); m_lock = 1'b0;
      m_val = '0; m_num = '0; m_ovr = 1'b0; m_tmo = 1'b0;
    end else begin
      dropped = 1'b0;
      if (m_phase == P_IDLE) begin
        if (bus.coeff_req) begin
          m_phase = P_COEFF; m_cnt = 1;
          m_val = bus.coeff_value; m_num = bus.coeff_num;
        end else if (!m_lock && m_q.size() != 0) begin
          m_phase = P_SAMPLE; m_cnt = 1; m_val = m_q.pop_front();
        end
      end else if (m_phase == P_WAIT) begin
        if (!bus.modwait) m_phase = P_IDLE;
      end else if (bus.modwait) begin
        if (m_phase == P_COEFF) m_lock = (m_num != 2'd3);
        m_phase = P_WAIT;
      end else if (m_cnt == TIMEOUT) begin
        m_phase = P_IDLE; m_lock = 1'b0; m_tmo = 1'b1;
      end else begin
        m_cnt++;
      end
      if (bus.sample_valid) begin
        if (m_q.size() < FIFO_DEPTH) m_q.push_back(bus.sample_value);
        else dropped = 1'b1;
      end
      if (dropped) m_ovr = 1'b1;
      else if (bus.clear_err) m_ovr = 1'b0;
      if (!(m_tmo && m_phase == P_IDLE && m_cnt == TIMEOUT) && bus.clear_err) m_tmo = 1'b0;
      if (m_phase == P_IDLE && m_cnt == TIMEOUT) m_cnt = 0;
    end
  end

  always @(negedge clk) begin
    chk("fir_load_coeff", 32'(bus.fir_load_coeff), 32'(m_phase == P_COEFF));
    chk("fir_data_ready", 32'(bus.fir_data_ready), 32'(m_phase == P_SAMPLE));
    chk("coeff_ack", 32'(bus.coeff_ack), 32'((m_phase == P_COEFF) && bus.modwait));
    chk("fir_value", 32'(bus.fir_value), 32'(m_val));
    chk("fir_coeff_num", 32'(bus.fir_coeff_num), 32'(m_num));
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_tmo));
    if (bus.coeff_ack) ack_cnt++;
    if (bus.fir_load_coeff && !prev_load) begin
      got_coeffs.push_back(bus.fir_value);
      got_nums.push_back(bus.fir_coeff_num);
    end
    if (bus.fir_data_ready && !prev_ready) got_samples.push_back(bus.fir_value);
    prev_load  = bus.fir_load_coeff;
    prev_ready = bus.fir_data_ready;
  end

  // FIR stand-in: mode 0 random lag/busy, 1 stuck busy, 2 never busy, 3 busy two cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (fir_mode == 1) begin
        bus.modwait = 1'b1;
      end else if (fir_mode == 2) begin
        bus.modwait = 1'b0; busy = 0; lag = 0;
      end else begin
        if (fir_mode == 3 && busy == 0) lag = 0;
        if (busy > 0) begin
          bus.modwait = 1'b1; busy--;
        end else if (bus.fir_load_coeff || bus.fir_data_ready) begin
          if (lag == 0) begin
            bus.modwait = 1'b1;
            busy = (fir_mode == 3) ? 1 : int'($urandom_range(2, 0));
            lag  = (fir_mode == 3) ? 0 : int'($urandom_range(3, 0));
          end else begin
            bus.modwait = 1'b0; lag--;
          end
        end else begin
          bus.modwait = 1'b0;
        end
      end
    end
  end

  task automatic load_coeff(input logic [1:0] num, input logic [15:0] val, input int gap);
    int start;
    int n;
    start = ack_cnt;
    n = 0;
    bus.coeff_req = 1'b1; bus.coeff_num = num; bus.coeff_value = val;
    while (ack_cnt == start && n < 100) begin
      tick();
      n++;
    end
    chk("coeff_ack_arrives", 32'(ack_cnt != start), 1);
    bus.coeff_req = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    int a0;
    int n;
    int req_ack;
    exp_s[0] = 16'h1001; exp_s[1] = 16'h1002; exp_s[2] = 16'h1003;
    exp_s[3] = 16'h1004; exp_s[4] = 16'h1005; exp_s[5] = 16'hCCCC;
    reset = 1'b1;
    bus.coeff_req = 1'b0; bus.coeff_num = '0; bus.coeff_value = '0;
    bus.sample_valid = 1'b0; bus.sample_value = '0;
    bus.modwait = 1'b0; bus.clear_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_load", 32'(bus.fir_load_coeff), 0);
    chk("reset_ready", 32'(bus.fir_data_ready), 0);
    chk("reset_value", 32'(bus.fir_value), 0);
    chk("reset_count", 32'(bus.fifo_count), 0);
    chk("reset_flags", 32'({bus.overrun, bus.timeout_err, bus.coeff_ack}), 0);
    tick();
    reset = 1'b0;
    tick();

    // Coefficient set with two samples arriving while the set is locked.
    fir_mode = 3;
    tick();
    got_coeffs.delete(); got_nums.delete(); got_samples.delete();
    a0 = ack_cnt;
    load_coeff(2'd0, 16'h0001, 6);
    bus.sample_valid = 1'b1; bus.sample_value = 16'hAAAA; tick();
    bus.sample_value = 16'hBBBB; tick();
    bus.sample_valid = 1'b0; repeat (4) tick();
    @(negedge clk);
    chk("lock_count", 32'(bus.fifo_count), 2);
    chk("lock_no_issue", 32'(got_samples.size()), 0);
    tick();
    load_coeff(2'd1, 16'h0002, 4);
    load_coeff(2'd2, 16'h0003, 4);
    @(negedge clk);
    chk("lock_count_late", 32'(bus.fifo_count), 2);
    tick();
    load_coeff(2'd3, 16'h0004, 0);
    repeat (20) tick();
    @(negedge clk);
    chk("ack_total", 32'(ack_cnt - a0), 4);
    chk("coeff_issues", 32'(got_coeffs.size()), 4);
    for (int i = 0; i < 4 && i < got_coeffs.size(); i++) begin
      chk($sformatf("coeff_value_%0d", i), 32'(got_coeffs[i]), 32'(i + 1));
      chk($sformatf("coeff_num_%0d", i), 32'(got_nums[i]), 32'(i));
    end
    chk("held_samples", 32'(got_samples.size()), 2);
    if (got_samples.size() == 2) begin
      chk("held_sample_0", 32'(got_samples[0]), 32'h0000AAAA);
      chk("held_sample_1", 32'(got_samples[1]), 32'h0000BBBB);
    end
    chk("drained_count", 32'(bus.fifo_count), 0);

    // Overrun with the FIR stuck busy.
    tick();
    fir_mode = 1;
    repeat (2) tick();
    got_samples.delete();
    for (int i = 0; i < 6; i++) begin
      bus.sample_valid = 1'b1;
      bus.sample_value = (i < 5) ? exp_s[i] : 16'hDEAD;
      tick();
    end
    bus.sample_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("full_count", 32'(bus.fifo_count), 4);
    chk("overrun_set", 32'(bus.overrun), 1);
    chk("first_issued", 32'(got_samples.size()), 1);
    tick();
    repeat (5) tick();
    @(negedge clk);
    chk("overrun_sticky", 32'(bus.overrun), 1);
    tick();
    bus.clear_err = 1'b1; tick();
    bus.clear_err = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", 32'(bus.overrun), 0);

    // Push coincident with pop on a full FIFO, then a sample timeout.
    tick();
    fir_mode = 2;
    tick(); tick();
    bus.sample_valid = 1'b1; bus.sample_value = 16'hCCCC; tick();
    bus.sample_valid = 1'b0;
    @(negedge clk);
    chk("full_pushpop_ready", 32'(bus.fir_data_ready), 1);
    chk("full_pushpop_count", 32'(bus.fifo_count), 4);
    chk("full_pushpop_overrun", 32'(bus.overrun), 0);
    n = 0;
    while (!bus.timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 16);
    chk("timeout_err_set", 32'(bus.timeout_err), 1);
    chk("timeout_idle", 32'(bus.fir_data_ready), 0);
    fir_mode = 0;
    repeat (60) tick();
    @(negedge clk);
    chk("sample_order_len", 32'(got_samples.size()), 6);
    for (int i = 0; i < 6 && i < got_samples.size(); i++)
      chk($sformatf("sample_order_%0d", i), 32'(got_samples[i]), 32'(exp_s[i]));
    tick();
    bus.clear_err = 1'b1; tick();
    bus.clear_err = 1'b0;
    @(negedge clk);
    chk("timeout_cleared", 32'(bus.timeout_err), 0);

    // Reset pulse in the middle of a coefficient issue.
    tick();
    fir_mode = 2;
    tick(); tick();
    a0 = ack_cnt;
    bus.coeff_req = 1'b1; bus.coeff_num = 2'd2; bus.coeff_value = 16'h1234;
    n = 0;
    while (!bus.fir_load_coeff && n < 10) begin
      tick();
      n++;
    end
    chk("coeff_latency", 32'(n), 1);
    bus.sample_valid = 1'b1; bus.sample_value = 16'h5555; tick();
    bus.sample_value = 16'h6666; tick();
    bus.sample_valid = 1'b0;
    chk("pre_reset_count", 32'(bus.fifo_count), 2);
    reset = 1'b1;
    #1;
    chk("reset_drops_strobe", 32'(bus.fir_load_coeff), 0);
    chk("reset_empties_fifo", 32'(bus.fifo_count), 0);
    chk("reset_no_ack", 32'(bus.coeff_ack), 0);
    bus.coeff_req = 1'b0;
    tick(); tick();
    reset = 1'b0;
    fir_mode = 0;
    tick();
    @(negedge clk);
    chk("post_reset_idle", 32'({bus.fir_load_coeff, bus.fir_data_ready}), 0);
    chk("post_reset_no_ack", 32'(ack_cnt - a0), 0);

    // Randomized traffic against the model.
    tick();
    req_ack = ack_cnt;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (c % 100 == 0) fir_mode = ($urandom_range(4, 0) == 0) ? 2 : 0;
      bus.sample_valid = ($urandom_range(3, 0) == 0);
      bus.sample_value = 16'($urandom);
      bus.clear_err    = ($urandom_range(15, 0) == 0);
      if (bus.coeff_req) begin
        if (ack_cnt != req_ack) bus.coeff_req = 1'b0;
      end else if ($urandom_range(9, 0) == 0) begin
        bus.coeff_req   = 1'b1;
        bus.coeff_num   = 2'($urandom_range(3, 0));
        bus.coeff_value = 16'($urandom);
        req_ack = ack_cnt;
      end
    end
    bus.sample_valid = 1'b0; bus.clear_err = 1'b0; bus.coeff_req = 1'b0;
    fir_mode = 0;
    repeat (40) tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
